// File: rtl/program_counter.sv
// ============================================================================
// program_counter : CPU instruction-address register with reset/load/increment
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module program_counter #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] INC_STEP    = DATA_WIDTH'(1),
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  increment,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] pc_in,
  output logic [DATA_WIDTH-1:0] pc_out
);

  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] w_pc_inc;

  // Carry out of the MSB is dropped, giving modulo-2^DATA_WIDTH wrap.
  assign w_pc_inc = r_pc + INC_STEP;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_VALUE;
    end else if (load) begin
      r_pc <= pc_in;
    end else if (increment) begin
      r_pc <= w_pc_inc;
    end
  end

  assign pc_out = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_program_counter.sv
// ============================================================================
// tb_program_counter : directed self-checking bench for program_counter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_program_counter;

  logic        clk;
  logic        reset;
  logic        increment;
  logic        load;
  logic [31:0] pc_in;
  logic [31:0] pc_out;
  logic [31:0] pc_out4;

  int vectors;
  int miscompares;

  // Default-parameter instance
  program_counter #(
    .DATA_WIDTH (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .increment (increment),
    .load      (load),
    .pc_in     (pc_in),
    .pc_out    (pc_out)
  );

  // Step-of-4, non-zero reset instance sharing the same stimulus
  program_counter #(
    .DATA_WIDTH  (32),
    .INC_STEP    (32'd4),
    .RESET_VALUE (32'h0000_1000)
  ) dut4 (
    .clk       (clk),
    .reset     (reset),
    .increment (increment),
    .load      (load),
    .pc_in     (pc_in),
    .pc_out    (pc_out4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; load = 1'b1; increment = 1'b1; pc_in = 32'hDEAD_BEEF;
    tick();
    vectors++;
    if (pc_out !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_override got=%h exp=%h", pc_out, 32'h0);
    end
    reset = 1'b0; load = 1'b0; increment = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (pc_out !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_hold[%0d] got=%h exp=%h", i, pc_out, 32'h0);
      end
    end
  endtask

  task automatic test_increment;
    logic [31:0] exp_tab [3];
    exp_tab[0] = 32'h1; exp_tab[1] = 32'h2; exp_tab[2] = 32'h2;
    for (int i = 0; i < 3; i++) begin
      increment = (i < 2);
      tick();
      vectors++;
      if (pc_out !== exp_tab[i]) begin
        miscompares++;
        $display("FAIL increment[%0d] got=%h exp=%h", i, pc_out, exp_tab[i]);
      end
    end
  endtask

  task automatic test_load;
    pc_in = 32'h0000_0010; load = 1'b1; increment = 1'b0;
    tick();
    vectors++;
    if (pc_out !== 32'h10) begin
      miscompares++;
      $display("FAIL load got=%h exp=%h", pc_out, 32'h10);
    end
    // pc_in must be ignored while load is low
    load = 1'b0; increment = 1'b1; pc_in = 32'h0000_ABCD;
    tick();
    vectors++;
    if (pc_out !== 32'h11) begin
      miscompares++;
      $display("FAIL load_inc1 got=%h exp=%h", pc_out, 32'h11);
    end
    tick();
    vectors++;
    if (pc_out !== 32'h12) begin
      miscompares++;
      $display("FAIL load_inc2 got=%h exp=%h", pc_out, 32'h12);
    end
    increment = 1'b0;
  endtask

  task automatic test_priority;
    pc_in = 32'h0000_0100; load = 1'b1; increment = 1'b1;
    tick();
    vectors++;
    if (pc_out !== 32'h100) begin
      miscompares++;
      $display("FAIL prio_load_over_inc got=%h exp=%h", pc_out, 32'h100);
    end
    reset = 1'b1;
    tick();
    vectors++;
    if (pc_out !== 32'h0) begin
      miscompares++;
      $display("FAIL prio_reset_over_all got=%h exp=%h", pc_out, 32'h0);
    end
    reset = 1'b0; load = 1'b0;
    tick();
    vectors++;
    if (pc_out !== 32'h1) begin
      miscompares++;
      $display("FAIL prio_after_reset got=%h exp=%h", pc_out, 32'h1);
    end
    increment = 1'b0;
  endtask

  task automatic test_wrap;
    pc_in = 32'hFFFF_FFFF; load = 1'b1;
    tick();
    vectors++;
    if (pc_out !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL wrap_load got=%h exp=%h", pc_out, 32'hFFFF_FFFF);
    end
    load = 1'b0; increment = 1'b1;
    tick();
    vectors++;
    if (pc_out !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_inc got=%h exp=%h", pc_out, 32'h0);
    end
    increment = 1'b0;
  endtask

  task automatic test_hold;
    pc_in = 32'h1234_5678; load = 1'b1;
    tick();
    load = 1'b0; pc_in = 32'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (pc_out !== 32'h1234_5678) begin
        miscompares++;
        $display("FAIL hold[%0d] got=%h exp=%h", i, pc_out, 32'h1234_5678);
      end
    end
  endtask

  task automatic test_params;
    logic [31:0] exp_tab [3];
    exp_tab[0] = 32'h1004; exp_tab[1] = 32'h1008; exp_tab[2] = 32'h100C;
    reset = 1'b1; load = 1'b1; increment = 1'b1; pc_in = 32'h5555_5555;
    tick();
    vectors++;
    if (pc_out4 !== 32'h1000) begin
      miscompares++;
      $display("FAIL param_reset got=%h exp=%h", pc_out4, 32'h1000);
    end
    reset = 1'b0; load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (pc_out4 !== exp_tab[i]) begin
        miscompares++;
        $display("FAIL param_inc[%0d] got=%h exp=%h", i, pc_out4, exp_tab[i]);
      end
    end
    increment = 1'b0; load = 1'b1; pc_in = 32'hFFFF_FFFE;
    tick();
    load = 1'b0; increment = 1'b1;
    tick();
    vectors++;
    if (pc_out4 !== 32'h2) begin
      miscompares++;
      $display("FAIL param_wrap got=%h exp=%h", pc_out4, 32'h2);
    end
    increment = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b0; increment = 1'b0; load = 1'b0; pc_in = 32'h0;
    @(negedge clk);
    test_reset();
    test_increment();
    test_load();
    test_priority();
    test_wrap();
    test_hold();
    test_params();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
